// File: rtl/rv32_pkg.sv
// Shared constants for the RV32M multiply/divide block: funct3 codes,
// datapath width and the sequencer state encoding.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] f);
    return f[2];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the issue stage and the mul/div unit.
interface muldiv_unit_if import rv32_pkg::*; ;

  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, flush, funct3, rs1_data, rs2_data, rd_in,
    input  busy, result_valid, result, rd_out
  );

  modport slave (
    input  start, flush, funct3, rs1_data, rs2_data, rd_in,
    output busy, result_valid, result, rd_out
  );

endinterface

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate: either two independent 32-bit halves
// or, with i_join set, one 64-bit value steered by i_neg_hi.
module md_sign_fix (
  input  logic        i_join,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic        i_neg_hi,
  input  logic        i_neg_lo,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [63:0] w_neg_wide;
  logic [31:0] w_neg_hi;
  logic [31:0] w_neg_lo;

  assign w_neg_wide = ~{i_hi, i_lo} + 64'd1;
  assign w_neg_hi   = ~i_hi + 32'd1;
  assign w_neg_lo   = ~i_lo + 32'd1;

  always_comb begin
    o_hi = i_hi;
    o_lo = i_lo;
    if (i_join) begin
      if (i_neg_hi) {o_hi, o_lo} = w_neg_wide;
    end else begin
      if (i_neg_hi) o_hi = w_neg_hi;
      if (i_neg_lo) o_lo = w_neg_lo;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide,
// one bit per cycle over a shared 64-bit accumulator.
//
// state   | meaning
// ST_IDLE | waiting for start; operands latched on accept
// ST_CALC | one multiply/divide iteration per cycle, 32 in total
// ST_DONE | sign correction and result write-back, single cycle
module muldiv_unit import rv32_pkg::*; #(
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  md_state_e r_state;
  md_state_e w_next;

  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_acc;
  logic [31:0]      r_opnd;
  logic [2:0]       r_f;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [4:0]       r_rd;
  logic [31:0]      r_result;
  logic [4:0]       r_rd_out;
  logic             r_valid;

  logic        w_accept;
  logic        w_special;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_mul_sum;
  logic [32:0] w_mul_hi;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_rem;
  logic [32:0] w_div_diff;
  logic [63:0] w_div_next;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;
  logic [31:0] w_sel;

  assign w_a_signed = (bus.funct3 == MD_MULH) || (bus.funct3 == MD_MULHSU) ||
                      (bus.funct3 == MD_DIV)  || (bus.funct3 == MD_REM);
  assign w_b_signed = (bus.funct3 == MD_MULH) || (bus.funct3 == MD_DIV) ||
                      (bus.funct3 == MD_REM);
  assign w_sa = w_a_signed & bus.rs1_data[31];
  assign w_sb = w_b_signed & bus.rs2_data[31];

  // Divide by zero and signed overflow bypass the iteration entirely.
  assign w_special = md_is_div(bus.funct3) &&
                     ((bus.rs2_data == 32'd0) ||
                      (!bus.funct3[0] && (bus.rs1_data == 32'h8000_0000) &&
                       (bus.rs2_data == 32'hFFFF_FFFF)));

  md_sign_fix u_entry_fix (
    .i_join   (1'b0),
    .i_hi     (bus.rs2_data),
    .i_lo     (bus.rs1_data),
    .i_neg_hi (w_sb),
    .i_neg_lo (w_sa),
    .o_hi     (w_abs_b),
    .o_lo     (w_abs_a)
  );

  md_sign_fix u_exit_fix (
    .i_join   (~md_is_div(r_f)),
    .i_hi     (r_acc[63:32]),
    .i_lo     (r_acc[31:0]),
    .i_neg_hi (md_is_div(r_f) ? r_neg_r : r_neg_q),
    .i_neg_lo (r_neg_q),
    .o_hi     (w_fix_hi),
    .o_lo     (w_fix_lo)
  );

  assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, r_opnd};
  assign w_mul_hi   = r_acc[0] ? w_mul_sum : {1'b0, r_acc[63:32]};
  assign w_mul_next = {w_mul_hi, r_acc[31:1]};

  // The partial remainder stays below the divisor, so a borrow out of the
  // 33-bit subtract is exactly the "remainder < divisor" condition.
  assign w_div_rem  = r_acc[63:31];
  assign w_div_diff = w_div_rem - {1'b0, r_opnd};
  assign w_div_next = w_div_diff[32] ? {w_div_rem[31:0], r_acc[30:0], 1'b0}
                                     : {w_div_diff[31:0], r_acc[30:0], 1'b1};

  always_comb begin
    w_sel = w_fix_hi;
    case (r_f)
      MD_MUL, MD_DIV, MD_DIVU: w_sel = w_fix_lo;
      default:                 w_sel = w_fix_hi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    if (bus.flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            w_accept = 1'b1;
            w_next   = w_special ? ST_DONE : ST_CALC;
          end
        end
        ST_CALC: if (r_cnt == CNT_W'(XLEN - 1)) w_next = ST_DONE;
        ST_DONE: w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_f      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rd     <= '0;
      r_result <= '0;
      r_rd_out <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        r_f   <= bus.funct3;
        r_rd  <= bus.rd_in;
        r_cnt <= '0;
        if (w_special) begin
          // Preload {remainder, quotient} with the architected answer.
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
          r_opnd  <= '0;
          r_acc   <= (bus.rs2_data == 32'd0) ? {bus.rs1_data, 32'hFFFF_FFFF}
                                             : {32'd0, 32'h8000_0000};
        end else begin
          r_neg_q <= w_sa ^ w_sb;
          r_neg_r <= w_sa;
          r_acc   <= md_is_div(bus.funct3) ? {32'd0, w_abs_a} : {32'd0, w_abs_b};
          r_opnd  <= md_is_div(bus.funct3) ? w_abs_b : w_abs_a;
        end
      end else if ((r_state == ST_CALC) && !bus.flush) begin
        r_acc <= md_is_div(r_f) ? w_div_next : w_mul_next;
        r_cnt <= r_cnt + CNT_W'(1);
      end else if ((r_state == ST_DONE) && !bus.flush) begin
        r_valid  <= 1'b1;
        r_result <= w_sel;
        r_rd_out <= r_rd;
      end
    end
  end

  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.result_valid = r_valid;
  assign bus.result       = r_result;
  assign bus.rd_out       = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized checks of muldiv_unit against a behavioural
// RV32M model, with expected results queued at issue and popped on result_valid.
module tb_muldiv_unit;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic rst;
  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sbv, ub, p;
    logic        [63:0] up;
    logic signed [31:0] qa, qb, qr;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ub  = {32'd0, b};
    up  = {32'd0, a} * {32'd0, b};
    qa  = a;
    qb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      MD_MUL:    return up[31:0];
      MD_MULH:   begin p = sa * sbv; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub;  return p[63:32]; end
      MD_MULHU:  return up[63:32];
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        qr = qa / qb;
        return qr;
      end
      MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        qr = qa % qb;
        return qr;
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op; optionally re-raise start (ignored) in cycle poke_at.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int poke_at);
    int   k, nbusy, exp_lat;
    bit   got;
    exp_t e;
    exp_lat = (f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
              ? 1 : 33;
    sb.push_back('{model(f, a, b), rd});
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = f; bus.rs1_data = a; bus.rs2_data = b; bus.rd_in = rd;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.funct3 = 3'($urandom); bus.rs1_data = $urandom; bus.rs2_data = $urandom;
    bus.rd_in = 5'($urandom);
    k = 0; nbusy = 0; got = 1'b0;
    while (!got && k < 100) begin
      if (bus.result_valid) begin
        got = 1'b1;
      end else begin
        if (bus.busy) nbusy++;
        if (poke_at != 0 && k == poke_at) begin
          bus.start = 1'b1; bus.funct3 = MD_MUL; bus.rs1_data = 32'd5; bus.rs2_data = 32'd5;
          bus.rd_in = 5'd31;
        end else begin
          bus.start = 1'b0;
        end
        @(posedge clk); #1;
        k++;
      end
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      n_cmp++; n_bad++;
      $error("FAIL timeout: observed no result_valid expected result 0x%h", e.res);
    end else begin
      check("latency", 32'(k), 32'(exp_lat));
      check("busy_cycles", 32'(nbusy), 32'(exp_lat));
      check("busy_at_valid", 32'(bus.busy), 32'd0);
      check("result", bus.result, e.res);
      check("rd_out", 32'(bus.rd_out), 32'(e.rd));
      last_res = e.res;
      last_rd  = e.rd;
      @(posedge clk); #1;
      check("valid_pulse", 32'(bus.result_valid), 32'd0);
      check("result_hold", bus.result, last_res);
    end
  endtask

  // Start an op, then abort it after `at` cycles with flush or rst.
  task automatic abort_op(input logic use_rst, input int at);
    int seen;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = MD_DIV; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd7;
    bus.rd_in = 5'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (at) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else bus.flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.flush = 1'b0;
    if (use_rst) begin
      last_res = '0;
      last_rd  = '0;
    end
    check(use_rst ? "rst_busy" : "flush_busy", 32'(bus.busy), 32'd0);
    check(use_rst ? "rst_valid" : "flush_valid", 32'(bus.result_valid), 32'd0);
    check(use_rst ? "rst_result" : "flush_result", bus.result, last_res);
    check(use_rst ? "rst_rd" : "flush_rd", 32'(bus.rd_out), 32'(last_rd));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.result_valid) seen++;
    end
    check(use_rst ? "rst_no_valid" : "flush_no_valid", 32'(seen), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.result_valid), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_rd", 32'(bus.rd_out), 32'd0);

    run_op(MD_MUL,    32'd7,          32'd6,          5'd5,  0);
    run_op(MD_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  0);
    run_op(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7,  0);
    run_op(MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd8,  0);
    run_op(MD_DIV,    32'hFFFF_FFF9,  32'd2,          5'd9,  0);
    run_op(MD_REM,    32'hFFFF_FFF9,  32'd2,          5'd10, 0);
    run_op(MD_DIVU,   32'd100,        32'd7,          5'd11, 0);
    run_op(MD_DIVU,   32'd123,        32'd0,          5'd12, 0);
    run_op(MD_REMU,   32'd123,        32'd0,          5'd13, 0);
    run_op(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 0);
    run_op(MD_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 0);
    run_op(MD_REM,    32'hFFFF_FFFB,  32'd0,          5'd16, 0);
    run_op(MD_DIV,    32'h8000_0000,  32'd3,          5'd0,  0);

    run_op(MD_DIVU,   32'd1000,       32'd10,         5'd17, 10);
    abort_op(1'b0, 15);
    run_op(MD_MUL,    32'd3,          32'd3,          5'd18, 0);
    abort_op(1'b1, 12);
    run_op(MD_MULH,   32'h8000_0000,  32'h7FFF_FFFF,  5'd19, 0);

    for (int i = 0; i < 8; i++) begin
      run_op(3'(i), $urandom, $urandom >> $urandom_range(0, 28), 5'(i + 20), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
